// File: rtl/stream_max_pool_if.sv
// rtl/stream_max_pool_if.sv - valid/ready bundle for the streaming pooler
//
// Carries both sides of the pooler's data path:
//   in_valid  / in_ready  / in_data              input pixel beat (raster order)
//   out_valid / out_ready / out_data / out_last  pooled pixel beat
// Channel c of a pixel sits at [c*DW +: DW] on both data buses.
// Modports: slave = the pooler itself, master = the upstream/downstream environment.

interface stream_max_pool_if #(
    parameter int CH = 4,
    parameter int DW = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [CH*DW-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [CH*DW-1:0]     out_data;
    logic                 out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/stream_max_pool.sv
// rtl/stream_max_pool.sv - streaming KxK stride-K max pooling over raster-order pixels
//
// Purpose: pools an IN_W x IN_H frame of CH-channel pixels into OUT_W x OUT_H pooled
// pixels (OUT_W = IN_W/POOL_K, OUT_H = IN_H/POOL_K). Only one output row of partial
// window results is kept (line buffer), plus one running row accumulator.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   soft_rst   synchronous clear, same effect as rst_n
//   bus        stream_max_pool_if.slave: in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_last
//   frame_err  sticky: a completed window would have overwritten an unconsumed output
//   pool_mode  (MAXPOOL_AVG_EN only) 0 = max, 1 = average; sampled with pixel (0,0)
// Optional feature: define MAXPOOL_AVG_EN to add average pooling (widened accumulators).

module stream_max_pool #(
    parameter int CH     = 4,
    parameter int DW     = 8,
    parameter int IN_W   = 28,
    parameter int IN_H   = 28,
    parameter int POOL_K = 2,
    parameter int SIGNED = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                soft_rst,
`ifdef MAXPOOL_AVG_EN
    input  logic                pool_mode,
`endif
    stream_max_pool_if.slave    bus,
    output logic                frame_err
);
    localparam int OUT_W = IN_W / POOL_K;
    localparam int OUT_H = IN_H / POOL_K;
    localparam int XW    = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int YW    = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int KW    = $clog2(POOL_K);
    localparam int CW    = $clog2(OUT_W + 1);
    localparam int RW    = $clog2(OUT_H + 1);
    localparam int AW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

`ifdef MAXPOOL_AVG_EN
    // Room for the sum of K*K values plus sign handling.
    localparam int EW = DW + 2 * $clog2(POOL_K);
    localparam int SH = 2 * $clog2(POOL_K);
    localparam logic [EW-1:0] SMAX = EW'((1 << (DW - 1)) - 1);
    localparam logic [EW-1:0] SMIN = ~SMAX;
    localparam logic [EW-1:0] UMAX = EW'((1 << DW) - 1);
`else
    localparam int EW = DW;
`endif

    // Position counters: x/y are raw pixel coordinates; kx/ky are the offset inside
    // the window and col/row the window index (col = OUT_W / row = OUT_H while cropping).
    logic [XW-1:0]       x_q;
    logic [YW-1:0]       y_q;
    logic [KW-1:0]       kx_q;
    logic [KW-1:0]       ky_q;
    logic [CW-1:0]       col_q;
    logic [RW-1:0]       row_q;

    logic [CH*EW-1:0]    hacc_q;
    logic [CH*EW-1:0]    lbuf [OUT_W];

    logic [CH*DW-1:0]    out_data_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                frame_err_q;

    logic                in_ready;
    logic                accept;
    logic                in_range;
    logic                col_end;
    logic                row_first;
    logic                row_last;
    logic                lb_we;
    logic                load;
    logic [AW-1:0]       col_idx;
    logic [CH*EW-1:0]    lb_rd;
    logic [CH*EW-1:0]    rmax;
    logic [CH*EW-1:0]    hacc_next;
    logic [CH*EW-1:0]    lb_next;
    logic [CH*DW-1:0]    res;

`ifdef MAXPOOL_AVG_EN
    logic                mode_q;
    logic                frame_start;
    logic                avg_mode;

    assign frame_start = (x_q == '0) && (y_q == '0);
    // The first pixel of a frame sees pool_mode directly; the rest of the frame uses the held copy.
    assign avg_mode    = frame_start ? pool_mode : mode_q;
`endif

    function automatic logic [EW-1:0] vmax(input logic [EW-1:0] a, input logic [EW-1:0] b);
        if (SIGNED != 0) begin
            return ($signed(a) > $signed(b)) ? a : b;
        end
        return (a > b) ? a : b;
    endfunction

    function automatic logic [EW-1:0] widen(input logic [DW-1:0] v);
`ifdef MAXPOOL_AVG_EN
        return {{(EW - DW){(SIGNED != 0) ? v[DW-1] : 1'b0}}, v};
`else
        return v;
`endif
    endfunction

    // Window reduction: max, or running sum in average mode.
    function automatic logic [EW-1:0] comb2(input logic [EW-1:0] a, input logic [EW-1:0] b);
`ifdef MAXPOOL_AVG_EN
        if (avg_mode) begin
            return a + b;
        end
`endif
        return vmax(a, b);
    endfunction

    // Reduce a finished window accumulator to an output value.
    function automatic logic [DW-1:0] narrow(input logic [EW-1:0] s);
`ifdef MAXPOOL_AVG_EN
        logic [EW-1:0] q;
        if (!avg_mode) begin
            return s[DW-1:0];
        end
        if (POOL_K == 3) begin
            if (SIGNED != 0) begin
                // Signed '/' truncates toward zero; bias negatives so the result floors.
                if ($signed(s) < 0) begin
                    q = ($signed(s) - $signed(EW'(8))) / $signed(EW'(9));
                end else begin
                    q = $signed(s) / $signed(EW'(9));
                end
            end else begin
                q = s / EW'(9);
            end
        end else if (SIGNED != 0) begin
            q = $signed(s) >>> SH;
        end else begin
            q = s >> SH;
        end
        if (SIGNED != 0) begin
            if ($signed(q) > $signed(SMAX)) begin
                q = SMAX;
            end else if ($signed(q) < $signed(SMIN)) begin
                q = SMIN;
            end
        end else if (q > UMAX) begin
            q = UMAX;
        end
        return q[DW-1:0];
`else
        return s;
`endif
    endfunction

    // Single output register: accept whenever it is empty or draining this cycle.
    assign in_ready      = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = in_ready;
    assign accept        = bus.in_valid && in_ready;
    assign in_range      = (col_q < CW'(OUT_W)) && (row_q < RW'(OUT_H));
    assign col_end       = (kx_q == KW'(POOL_K - 1));
    assign row_first     = (ky_q == '0);
    assign row_last      = (ky_q == KW'(POOL_K - 1));
    assign col_idx       = col_q[AW-1:0];
    assign lb_rd         = lbuf[col_idx];
    assign lb_we         = accept && in_range && col_end;
    assign load          = lb_we && row_last;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign frame_err     = frame_err_q;

    always_comb begin
        rmax      = '0;
        hacc_next = '0;
        lb_next   = '0;
        res       = '0;
        for (int c = 0; c < CH; c++) begin
            rmax[c*EW +: EW]      = comb2(hacc_q[c*EW +: EW], widen(bus.in_data[c*DW +: DW]));
            hacc_next[c*EW +: EW] = (kx_q == '0) ? widen(bus.in_data[c*DW +: DW]) : rmax[c*EW +: EW];
            // Row 0 of a window overwrites whatever the entry held from the previous window row.
            lb_next[c*EW +: EW]   = row_first ? rmax[c*EW +: EW]
                                              : comb2(lb_rd[c*EW +: EW], rmax[c*EW +: EW]);
            res[c*DW +: DW]       = narrow(lb_next[c*EW +: EW]);
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we) begin
            lbuf[col_idx] <= lb_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '0;
            y_q         <= '0;
            kx_q        <= '0;
            ky_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            hacc_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (soft_rst) begin
            x_q         <= '0;
            y_q         <= '0;
            kx_q        <= '0;
            ky_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            hacc_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (accept) begin
                if (in_range) begin
                    hacc_q <= hacc_next;
                end
                if (x_q == XW'(IN_W - 1)) begin
                    x_q   <= '0;
                    kx_q  <= '0;
                    col_q <= '0;
                    if (y_q == YW'(IN_H - 1)) begin
                        y_q   <= '0;
                        ky_q  <= '0;
                        row_q <= '0;
                    end else begin
                        y_q <= y_q + 1'b1;
                        if (row_last) begin
                            ky_q  <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            ky_q <= ky_q + 1'b1;
                        end
                    end
                end else begin
                    x_q <= x_q + 1'b1;
                    if (col_end) begin
                        kx_q  <= '0;
                        col_q <= col_q + 1'b1;
                    end else begin
                        kx_q <= kx_q + 1'b1;
                    end
                end
            end

            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= res;
                out_last_q  <= (col_q == CW'(OUT_W - 1)) && (row_q == RW'(OUT_H - 1));
                // Unreachable while in_ready gates acceptance; flags a broken handshake.
                if (out_valid_q && !bus.out_ready) begin
                    frame_err_q <= 1'b1;
                end
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

`ifdef MAXPOOL_AVG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else if (soft_rst) begin
            mode_q <= 1'b0;
        end else if (accept && frame_start) begin
            mode_q <= pool_mode;
        end
    end
`endif
endmodule

// File: tb/tb_stream_max_pool.sv
// tb/tb_stream_max_pool.sv - directed self-checking bench for stream_max_pool

module tb_stream_max_pool;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        soft_rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data;
    int          sel;
    int          checks   = 0;
    int          failures = 0;

    logic        err_a, err_s, err_u, err_c;
    logic        obs_in_ready, obs_valid, obs_last, obs_err;
    logic [15:0] obs_data;

    logic [7:0]  t2_pix [8] = '{8'hFD, 8'hFF, 8'hFD, 8'h01, 8'hF8, 8'hFE, 8'hF8, 8'h02};

    stream_max_pool_if #(.CH(2), .DW(8)) if_a ();
    stream_max_pool_if #(.CH(2), .DW(8)) if_s ();
    stream_max_pool_if #(.CH(2), .DW(8)) if_u ();
    stream_max_pool_if #(.CH(2), .DW(8)) if_c ();

    assign if_a.in_valid  = in_valid && (sel == 0);
    assign if_s.in_valid  = in_valid && (sel == 1);
    assign if_u.in_valid  = in_valid && (sel == 2);
    assign if_c.in_valid  = in_valid && (sel == 3);
    assign if_a.in_data   = in_data;
    assign if_s.in_data   = in_data;
    assign if_u.in_data   = in_data;
    assign if_c.in_data   = in_data;
    assign if_a.out_ready = out_ready;
    assign if_s.out_ready = out_ready;
    assign if_u.out_ready = out_ready;
    assign if_c.out_ready = out_ready;

    stream_max_pool #(.CH(2), .DW(8), .IN_W(4), .IN_H(4), .POOL_K(2), .SIGNED(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .bus(if_a.slave), .frame_err(err_a));
    stream_max_pool #(.CH(2), .DW(8), .IN_W(4), .IN_H(2), .POOL_K(2), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .bus(if_s.slave), .frame_err(err_s));
    stream_max_pool #(.CH(2), .DW(8), .IN_W(4), .IN_H(2), .POOL_K(2), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .bus(if_u.slave), .frame_err(err_u));
    stream_max_pool #(.CH(2), .DW(8), .IN_W(5), .IN_H(5), .POOL_K(2), .SIGNED(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .bus(if_c.slave), .frame_err(err_c));

    always_comb begin
        obs_in_ready = if_a.in_ready;
        obs_valid    = if_a.out_valid;
        obs_data     = if_a.out_data;
        obs_last     = if_a.out_last;
        obs_err      = err_a;
        case (sel)
            1: begin
                obs_in_ready = if_s.in_ready; obs_valid = if_s.out_valid;
                obs_data = if_s.out_data; obs_last = if_s.out_last; obs_err = err_s;
            end
            2: begin
                obs_in_ready = if_u.in_ready; obs_valid = if_u.out_valid;
                obs_data = if_u.out_data; obs_last = if_u.out_last; obs_err = err_u;
            end
            3: begin
                obs_in_ready = if_c.in_ready; obs_valid = if_c.out_valid;
                obs_data = if_c.out_data; obs_last = if_c.out_last; obs_err = err_c;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One accepted beat, then check what the output register shows one cycle later.
    task automatic beat(input logic [15:0] d, input logic ev, input logic [15:0] ed,
                        input logic el, input string tag);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        chk({tag, " in_ready"}, 16'(obs_in_ready), 16'h1);
        step();
        in_valid = 1'b0;
        chk({tag, " out_valid"}, 16'(obs_valid), 16'(ev));
        if (ev) begin
            chk({tag, " out_data"}, obs_data, ed);
            chk({tag, " out_last"}, 16'(obs_last), 16'(el));
        end
    endtask

    // 4x4 ramp on dut_a: ch0 = i, ch1 = 255 - i, so ch1 pools the window minimum.
    task automatic beat_a(input int i, input string tag);
        logic [15:0] ed;
        logic        ev;
        ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
        case (i)
            5:       ed = 16'hFF05;
            7:       ed = 16'hFD07;
            13:      ed = 16'hF70D;
            15:      ed = 16'hF50F;
            default: ed = 16'h0000;
        endcase
        beat({8'(255 - i), 8'(i)}, ev, ed, (i == 15), $sformatf("%s beat%0d", tag, i));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        soft_rst  = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b1;
        sel       = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 16'(obs_valid), 16'h0);
        chk("reset out_data", obs_data, 16'h0);
        chk("reset out_last", 16'(obs_last), 16'h0);
        chk("reset frame_err", 16'(obs_err), 16'h0);
        rst_n = 1'b1;
        #1;
        chk("reset in_ready", 16'(obs_in_ready), 16'h1);

        // T1: 4x4 ramp, always ready
        for (int i = 0; i < 16; i++) beat_a(i, "T1");
        step();
        chk("T1 drain out_valid", 16'(obs_valid), 16'h0);

        // T4: stall the first result for 10 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) beat_a(i, "T4");
        in_valid = 1'b1;
        in_data  = {8'(255 - 6), 8'(6)};
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("T4 stall%0d in_ready", k), 16'(obs_in_ready), 16'h0);
            chk($sformatf("T4 stall%0d out_data", k), obs_data, 16'hFF05);
            chk($sformatf("T4 stall%0d out_valid", k), 16'(obs_valid), 16'h1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("T4 release in_ready", 16'(obs_in_ready), 16'h1);
        step();
        in_valid = 1'b0;
        chk("T4 release out_valid", 16'(obs_valid), 16'h0);
        for (int i = 7; i < 16; i++) beat_a(i, "T4");
        chk("T4 frame_err", 16'(obs_err), 16'h0);

        // T5: soft reset mid-frame, then a clean frame
        for (int i = 0; i < 6; i++) beat_a(i, "T5pre");
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        chk("T5 soft_rst out_valid", 16'(obs_valid), 16'h0);
        chk("T5 soft_rst out_data", obs_data, 16'h0);
        chk("T5 soft_rst out_last", 16'(obs_last), 16'h0);
        for (int i = 0; i < 16; i++) beat_a(i, "T5");
        chk("T5 frame_err", 16'(obs_err), 16'h0);

        // T2: signed vs unsigned compare on the same bytes
        sel = 1;
        for (int i = 0; i < 8; i++)
            beat({8'h00, t2_pix[i]}, (i == 5) || (i == 7), (i == 5) ? 16'h00FF : 16'h0002,
                 (i == 7), $sformatf("T2s beat%0d", i));
        sel = 2;
        for (int i = 0; i < 8; i++)
            beat({8'h00, t2_pix[i]}, (i == 5) || (i == 7), (i == 5) ? 16'h00FF : 16'h00FD,
                 (i == 7), $sformatf("T2u beat%0d", i));

        // T3: 5x5 frame, last column and row cropped, then wrap to (0,0)
        sel = 3;
        for (int i = 0; i < 25; i++)
            beat({8'h00, 8'(i)}, (i == 6) || (i == 8) || (i == 16) || (i == 18),
                 16'(i), (i == 18), $sformatf("T3 beat%0d", i));
        for (int i = 0; i < 7; i++)
            beat({8'h00, 8'(i)}, (i == 6), 16'h0006, 1'b0, $sformatf("T3wrap beat%0d", i));
        chk("T3 frame_err", 16'(obs_err), 16'h0);

        chk("final frame_err a", 16'(err_a), 16'h0);
        chk("final frame_err s", 16'(err_s), 16'h0);
        chk("final frame_err u", 16'(err_u), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
